axi_burst_master: RTL and testbench

Synthesizable single-outstanding AXI4 burst initiator that converts a simple command/stream interface into AXI write-address, write-data, write-response, read-address and read-data channel traffic. It sits between on-chip logic (DMA-style engines, bring-up controllers) and the AMBA_AXI_ram slave, replacing testbench-driven stimulus with an RTL master. Only INCR bursts are issued, and exactly one transaction is in flight at a time.

---
 rtl/axi_burst_master.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator.
// Bridges a command/stream interface onto the five AXI channels.
module axi_burst_master #(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int BRESP_WIDTH  = 3,
  parameter int STROBE_WIDTH = DATA_WIDTH/8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,

  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [STROBE_WIDTH-1:0] wr_strb,

  output logic                    rd_data_valid,
  input  logic                    rd_data_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,

  output logic                    done,
  output logic [BRESP_WIDTH-1:0]  done_resp,
  output logic                    done_err,

  output logic                    m_axi_awvalid,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  input  logic                    m_axi_awready,

  output logic                    m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STROBE_WIDTH-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_wready,

  output logic                    m_axi_bready,
  input  logic                    m_axi_bvalid,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [BRESP_WIDTH-1:0]  m_axi_bresp,

  output logic                    m_axi_arvalid,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_arready,

  output logic                    m_axi_rready,
  input  logic                    m_axi_rvalid,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [BRESP_WIDTH-1:0]  m_axi_rresp,
  input  logic                    m_axi_rlast
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;

  localparam logic [1:0] BURST_INCR = 2'b01;

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic                   alive_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [7:0]             len_q;
  logic [2:0]             size_q;
  logic [7:0]             cnt_q;
  logic [BRESP_WIDTH-1:0] resp_q;
  logic                   err_q;
  logic                   done_q;
  logic [BRESP_WIDTH-1:0] done_resp_q;
  logic                   done_err_q;

  logic st_idle;
  logic st_aw;
  logic st_w;
  logic st_b;
  logic st_ar;
  logic st_r;

  logic                   cmd_fire;
  logic                   w_fire;
  logic                   b_fire;
  logic                   r_fire;
  logic                   r_end;
  logic                   last_beat;
  logic                   r_beat_err;
  logic [BRESP_WIDTH-1:0] r_resp_sel;

  assign st_idle = (state_q == S_IDLE);
  assign st_aw   = (state_q == S_AW);
  assign st_w    = (state_q == S_W);
  assign st_b    = (state_q == S_B);
  assign st_ar   = (state_q == S_AR);
  assign st_r    = (state_q == S_R);

  // cmd_ready is held off until the first clock after reset release
  assign cmd_ready = alive_q & st_idle;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign last_beat = (cnt_q == len_q);
  assign w_fire    = st_w & wr_data_valid & m_axi_wready;
  assign b_fire    = st_b & m_axi_bvalid;
  assign r_fire    = st_r & m_axi_rvalid & rd_data_ready;
  assign r_end     = r_fire & (m_axi_rlast | last_beat);

  assign r_beat_err = (m_axi_rid != id_q)
                    | (m_axi_rlast != last_beat);
  assign r_resp_sel = (resp_q != '0) ? resp_q : m_axi_rresp;

  assign m_axi_awvalid = st_aw;
  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = st_aw ? BURST_INCR : 2'b00;

  assign m_axi_arvalid = st_ar;
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = st_ar ? BURST_INCR : 2'b00;

  assign m_axi_wvalid  = st_w & wr_data_valid;
  assign wr_data_ready = st_w & m_axi_wready;
  assign m_axi_wdata   = st_w ? wr_data : '0;
  assign m_axi_wstrb   = st_w ? wr_strb : '0;
  assign m_axi_wlast   = st_w & last_beat;

  assign m_axi_bready  = st_b;

  assign rd_data_valid = st_r & m_axi_rvalid;
  assign m_axi_rready  = st_r & rd_data_ready;
  assign rd_data       = st_r ? m_axi_rdata : '0;
  assign rd_last       = st_r & m_axi_rlast;

  assign done      = done_q;
  assign done_resp = done_resp_q;
  assign done_err  = done_err_q;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle: if (cmd_fire)
                 state_d = cmd_write ? S_AW : S_AR;
      st_aw:   if (m_axi_awready) state_d = S_W;
      st_w:    if (w_fire && last_beat)
                 state_d = S_B;
      st_b:    if (m_axi_bvalid) state_d = S_IDLE;
      st_ar:   if (m_axi_arready) state_d = S_R;
      st_r:    if (r_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alive_q     <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      done_resp_q <= '0;
      done_err_q  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      state_q <= state_d;
      done_q  <= 1'b0;
      if (cmd_fire) begin
        id_q   <= cmd_id;
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        size_q <= cmd_size;
        cnt_q  <= '0;
        resp_q <= '0;
        err_q  <= 1'b0;
      end
      if (w_fire) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (b_fire) begin
        done_q      <= 1'b1;
        done_resp_q <= m_axi_bresp;
        done_err_q  <= (m_axi_bid != id_q);
      end
      if (r_fire) begin
        cnt_q <= cnt_q + 8'd1;
        err_q <= err_q | r_beat_err;
        if (resp_q == '0)
          resp_q <= m_axi_rresp;
      end
      // early rlast or missing rlast both end the burst as errors
      if (r_end) begin
        done_q      <= 1'b1;
        done_resp_q <= r_resp_sel;
        done_err_q  <= err_q | r_beat_err;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master.
// Acts as user and AXI slave; expectations come from burst rules.
module tb_axi_burst_master;

  localparam int IW = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int SW = DW/8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [IW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic          wr_data_valid, wr_data_ready;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_data_valid, rd_data_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic [RW-1:0] done_resp;
  logic          done_err;
  logic          m_axi_awvalid, m_axi_awready;
  logic [IW-1:0] m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_bready, m_axi_bvalid;
  logic [IW-1:0] m_axi_bid;
  logic [RW-1:0] m_axi_bresp;
  logic          m_axi_arvalid, m_axi_arready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_rready, m_axi_rvalid, m_axi_rlast;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [RW-1:0] m_axi_rresp;

  axi_burst_master #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .BRESP_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size),
    .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .done_err(done_err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wready(m_axi_wready),
    .m_axi_bready(m_axi_bready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arready(m_axi_arready),
    .m_axi_rready(m_axi_rready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] wq_data[$];
  logic [SW-1:0] wq_strb[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int len);
    wq_data.delete();
    wq_strb.delete();
    for (int k = 0; k <= len; k++) begin
      wq_data.push_back(DW'($urandom));
      wq_strb.push_back(SW'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) check("done_pulse", done, 0);
    end
  endtask

  task automatic send_cmd(input logic wr,
                          input logic [IW-1:0] id,
                          input logic [AW-1:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    #1;
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    cmd_id    = IW'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = 8'($urandom);
    cmd_size  = 3'($urandom);
  endtask

  task automatic addr_phase(input logic wr,
                            input logic [IW-1:0] id,
                            input logic [AW-1:0] addr,
                            input logic [7:0] len,
                            input logic [2:0] size,
                            input int stall);
    int cyc = 0;
    logic hs = 1'b0;
    logic rdy;
    while (!hs && cyc < 100) begin
      rdy = (cyc >= stall) && ($urandom_range(0, 2) != 0);
      m_axi_awready = wr & rdy;
      m_axi_arready = ~wr & rdy;
      #1;
      if (cyc == 0) check("done_low", done, 0);
      check("cmd_ready_busy", cmd_ready, 0);
      if (wr) begin
        check("awvalid", m_axi_awvalid, 1);
        check("awid", m_axi_awid, id);
        check("awaddr", m_axi_awaddr, addr);
        check("awlen", m_axi_awlen, len);
        check("awsize", m_axi_awsize, size);
        check("awburst", m_axi_awburst, 1);
        check("arvalid_off", m_axi_arvalid, 0);
      end else begin
        check("arvalid", m_axi_arvalid, 1);
        check("arid", m_axi_arid, id);
        check("araddr", m_axi_araddr, addr);
        check("arlen", m_axi_arlen, len);
        check("arsize", m_axi_arsize, size);
        check("arburst", m_axi_arburst, 1);
        check("awvalid_off", m_axi_awvalid, 0);
      end
      hs = rdy;
      @(posedge clk); @(negedge clk);
      m_axi_awready = 1'b0;
      m_axi_arready = 1'b0;
      cyc++;
    end
    check("addr_hs", hs, 1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_wr_rdy", wr_data_ready, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_rd_valid", rd_data_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_done_err", done_err, 0);
    check("rst_awburst", m_axi_awburst, 0);
    @(posedge clk); @(negedge clk);
    wr_data_valid = 1'b0;
    m_axi_wready  = 1'b0;
    rst_n = 1'b1;
    #1;
    check("cmd_ready_pre", cmd_ready, 0);
    @(posedge clk); @(negedge clk);
    check("cmd_ready_post", cmd_ready, 1);
    check("done_post_rst", done, 0);
  endtask

  task automatic w_phase(input logic [7:0] len,
                         input int abort_at,
                         input bit toggle,
                         output bit aborted);
    int i = 0;
    int cyc = 0;
    logic v, r;
    aborted = 1'b0;
    while (i <= int'(len) && cyc < 3000) begin
      if (abort_at >= 0 && i == abort_at) begin
        wr_data_valid = 1'b1;
        wr_data = wq_data[i];
        wr_strb = wq_strb[i];
        m_axi_wready = 1'b1;
        #1;
        check("pre_rst_wvalid", m_axi_wvalid, 1);
        reset_pulse();
        aborted = 1'b1;
        return;
      end
      v = ($urandom_range(0, 3) != 0);
      r = toggle ? cyc[0] : 1'($urandom_range(0, 1));
      wr_data_valid = v;
      wr_data = v ? wq_data[i] : DW'($urandom);
      wr_strb = v ? wq_strb[i] : SW'($urandom);
      m_axi_wready = r;
      #1;
      check("wvalid", m_axi_wvalid, v);
      check("wr_data_ready", wr_data_ready, r);
      if (v) begin
        check("wdata", m_axi_wdata, wq_data[i]);
        check("wstrb", m_axi_wstrb, wq_strb[i]);
        check("wlast", m_axi_wlast, (i == int'(len)));
      end
      @(posedge clk);
      if (v && r) i++;
      @(negedge clk);
      cyc++;
    end
    wr_data_valid = 1'b0;
    m_axi_wready  = 1'b0;
    check("w_beats", i, 32'(len) + 1);
  endtask

  task automatic b_phase(input logic [IW-1:0] id,
                         input logic [IW-1:0] bid_v,
                         input logic [RW-1:0] bresp_v);
    int cyc = 0;
    logic hs = 1'b0;
    logic v;
    m_axi_bid   = bid_v;
    m_axi_bresp = bresp_v;
    while (!hs && cyc < 100) begin
      v = 1'($urandom_range(0, 1));
      m_axi_bvalid = v;
      #1;
      check("bready", m_axi_bready, 1);
      check("done_early", done, 0);
      hs = v;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    m_axi_bvalid = 1'b0;
    m_axi_bid    = IW'($urandom);
    m_axi_bresp  = RW'($urandom);
    #1;
    check("b_hs", hs, 1);
    check("w_done", done, 1);
    check("w_done_resp", done_resp, bresp_v);
    check("w_done_err", done_err, (bid_v != id));
    check("w_done_cmd_ready", cmd_ready, 1);
    check("bready_off", m_axi_bready, 0);
  endtask

  task automatic do_write(input logic [IW-1:0] id,
                          input logic [AW-1:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size,
                          input int stall,
                          input bit toggle,
                          input logic [IW-1:0] bid_v,
                          input logic [RW-1:0] bresp_v,
                          input int abort_at);
    bit aborted;
    send_cmd(1'b1, id, addr, len, size);
    addr_phase(1'b1, id, addr, len, size, stall);
    w_phase(len, abort_at, toggle, aborted);
    if (!aborted) b_phase(id, bid_v, bresp_v);
  endtask

  // early_at: beat index carrying rlast too soon (-1 none)
  // late: slave never raises rlast
  // bad_id_at: beat index returning a wrong rid (-1 none)
  task automatic do_read(input logic [IW-1:0] id,
                         input logic [AW-1:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input int early_at,
                         input bit late,
                         input int bad_id_at);
    int i = 0;
    int cyc = 0;
    int last_idx;
    int exp_beats;
    bit fin = 1'b0;
    bit exp_err = 1'b0;
    logic [RW-1:0] exp_resp = '0;
    logic v, rdy, rl;
    logic [IW-1:0] rid;
    send_cmd(1'b0, id, addr, len, size);
    addr_phase(1'b0, id, addr, len, size, 0);
    last_idx = (early_at >= 0) ? early_at : int'(len);
    if (late) exp_beats = int'(len) + 1;
    else if (last_idx < int'(len)) exp_beats = last_idx + 1;
    else exp_beats = int'(len) + 1;
    while (!fin && cyc < 3000) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      rl  = (i == last_idx) && !late;
      rid = (i == bad_id_at) ? (id ^ 4'h1) : id;
      m_axi_rvalid = v;
      rd_data_ready = rdy;
      m_axi_rid   = rid;
      m_axi_rlast = rl;
      m_axi_rdata = DW'($urandom);
      m_axi_rresp = ($urandom_range(0, 3) == 0) ?
                    RW'($urandom_range(1, 7)) : '0;
      #1;
      check("rd_valid", rd_data_valid, v);
      check("rready", m_axi_rready, rdy);
      check("done_early_r", done, 0);
      if (v) begin
        check("rd_data", rd_data, m_axi_rdata);
        check("rd_last", rd_last, rl);
      end
      if (v && rdy) begin
        if (rid != id || rl != (i == int'(len))) exp_err = 1'b1;
        if (exp_resp == '0) exp_resp = m_axi_rresp;
        if (rl || i == int'(len)) fin = 1'b1;
        i++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    m_axi_rvalid  = 1'b0;
    rd_data_ready = 1'b0;
    m_axi_rlast   = 1'b0;
    #1;
    check("r_fin", fin, 1);
    check("r_beats", i, exp_beats);
    check("r_done", done, 1);
    check("r_done_resp", done_resp, exp_resp);
    check("r_done_err", done_err, exp_err);
    check("r_done_cmd_ready", cmd_ready, 1);
    check("rready_off", m_axi_rready, 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_id = 0;
    cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    wr_data_valid = 0; wr_data = 0; wr_strb = 0;
    rd_data_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_bid = 0; m_axi_bresp = 0;
    m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rid = 0; m_axi_rdata = 0;
    m_axi_rresp = 0; m_axi_rlast = 0;

    @(negedge clk);
    reset_pulse();

    wq_data = '{16'h0a0b, 16'h0a0b, 16'h0c0d, 16'h0c0d};
    wq_strb = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_write(4'd2, 4'd0, 8'd3, 3'd0, 0, 0, 4'd2, 3'd0, -1);
    idle(2);
    do_read(4'd2, 4'd0, 8'd3, 3'd0, -1, 0, -1);
    idle(1);

    fill_random(3);
    do_write(4'd5, 4'd6, 8'd3, 3'd1, 5, 1, 4'd5, 3'd0, -1);
    idle(1);

    fill_random(3);
    do_write(4'd2, 4'd0, 8'd3, 3'd0, 0, 0, 4'd3, 3'd2, -1);
    idle(1);
    do_read(4'd2, 4'd0, 8'd3, 3'd0, 1, 0, -1);
    idle(1);
    do_read(4'd4, 4'd8, 8'd2, 3'd1, -1, 1, -1);
    idle(1);
    do_read(4'd7, 4'd2, 8'd4, 3'd0, -1, 0, 2);
    idle(1);

    fill_random(3);
    do_write(4'd2, 4'd0, 8'd3, 3'd0, 0, 0, 4'd2, 3'd0, 1);
    fill_random(2);
    do_write(4'd3, 4'd4, 8'd2, 3'd1, 0, 0, 4'd3, 3'd1, -1);
    idle(1);

    fill_random(0);
    do_write(4'd1, 4'd0, 8'd0, 3'd0, 0, 0, 4'd1, 3'd0, -1);
    do_read(4'd1, 4'd0, 8'd1, 3'd0, -1, 0, -1);
    fill_random(1);
    do_write(4'd9, 4'd2, 8'd1, 3'd1, 0, 0, 4'd9, 3'd0, -1);
    idle(1);

    fill_random(255);
    do_write(4'd6, 4'd0, 8'd255, 3'd1, 0, 0, 4'd6, 3'd0, -1);
    idle(1);

    for (int t = 0; t < 30; t++) begin
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      id   = IW'($urandom);
      addr = AW'($urandom);
      len  = 8'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        fill_random(int'(len));
        do_write(id, addr, len, size,
                 $urandom_range(0, 3), 0,
                 ($urandom_range(0, 3) == 0) ? id + 4'd1 : id,
                 RW'($urandom), -1);
      end else begin
        int sel;
        sel = $urandom_range(0, 5);
        do_read(id, addr, len, size,
                (sel == 0) ? $urandom_range(0, int'(len)) : -1,
                (sel == 1),
                (sel == 2) ? $urandom_range(0, int'(len)) : -1);
      end
      idle($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
